// File: rtl/gpr_operand_fetch.sv
// GPR operand fetch: sequences up to three source reads per thread
// through the single synchronous RF read port, with writeback forwarding.
module gpr_operand_fetch #(
    parameter logic ZERO_BYPASS = 1'b0,
    parameter int   NOPS        = 3,
    parameter int   TidMSB      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [TidMSB:0]     i_req_tid,
    input  logic [5:0]          i_req_ra,
    input  logic [5:0]          i_req_rb,
    input  logic [5:0]          i_req_rc,
    input  logic [2:0]          i_req_mask,
    output logic [TidMSB+6:0]   o_rf_ra,
    input  logic [31:0]         i_rf_o,
    input  logic [3:0]          i_wb_wr,
    input  logic [TidMSB+6:0]   i_wb_wa,
    input  logic [31:0]         i_wb_i,
    output logic                o_opnd_valid,
    input  logic                i_opnd_ready,
    output logic [TidMSB:0]     o_opnd_tid,
    output logic [31:0]         o_opnd_a,
    output logic [31:0]         o_opnd_b,
    output logic [31:0]         o_opnd_c
);

    localparam int SW = $clog2(NOPS);
    localparam int AW = TidMSB + 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPL
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic            w_done;
    logic            w_accept;
    logic            w_hold;

    logic [TidMSB:0] r_tid;
    logic [5:0]      r_regno [NOPS];
    logic [NOPS-1:0] r_mask;
    logic [NOPS-1:0] r_pend;
    logic [SW-1:0]   r_cur;
    logic [AW-1:0]   r_rf_ra;

    logic            r_cap_vld;
    logic [SW-1:0]   r_cap_slot;
    logic [AW-1:0]   r_cap_addr;
    logic            r_cap_zero;

    logic [31:0]     r_opnd [NOPS];
    logic            r_opnd_valid;
    logic [TidMSB:0] r_opnd_tid;

    logic [5:0]      w_req_regno [NOPS];
    logic [AW-1:0]   w_addr [NOPS];
    logic            w_zero [NOPS];
    logic [SW-1:0]   w_req_first;
    logic [SW-1:0]   w_pend_first;
    logic [31:0]     w_cap_val;

    function automatic logic [SW-1:0] lowest(input logic [NOPS-1:0] m);
        logic [SW-1:0] s;
        s = '0;
        for (int k = NOPS - 1; k >= 0; k--) begin
            if (m[k]) s = SW'(k);
        end
        return s;
    endfunction

    function automatic logic [NOPS-1:0] onehot(input logic [SW-1:0] s);
        return NOPS'(1) << s;
    endfunction

    function automatic logic [31:0] merge(
        input logic [31:0] base,
        input logic [31:0] nw,
        input logic [3:0]  en
    );
        logic [31:0] r;
        r = base;
        for (int j = 0; j < 4; j++) begin
            if (en[j]) r[8*j +: 8] = nw[8*j +: 8];
        end
        return r;
    endfunction

    assign w_req_regno[0] = i_req_ra;
    assign w_req_regno[1] = i_req_rb;
    assign w_req_regno[2] = i_req_rc;

    always_comb begin
        for (int k = 0; k < NOPS; k++) begin
            w_addr[k] = {r_tid, r_regno[k]};
            w_zero[k] = ZERO_BYPASS && (r_regno[k] == 6'd0);
        end
    end

    assign w_req_first  = lowest(i_req_mask);
    assign w_pend_first = lowest(r_pend);

    assign o_req_ready = !i_rst && (r_state == S_IDLE) &&
                         (!r_opnd_valid || i_opnd_ready);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_hold      = r_opnd_valid && !i_opnd_ready;

    // Same-cycle writeback wins per byte over the stale RF read data.
    always_comb begin
        w_cap_val = i_rf_o;
        if (i_wb_wa == r_cap_addr) w_cap_val = merge(i_rf_o, i_wb_i, i_wb_wr);
        if (r_cap_zero) w_cap_val = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = (i_req_mask != '0) ? S_ISSUE : S_CAPL;
                end
            end
            S_ISSUE: begin
                if (r_pend == '0) w_state_nx = S_CAPL;
            end
            S_CAPL: begin
                w_state_nx = S_IDLE;
                w_done     = 1'b1;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tid        <= '0;
            r_mask       <= '0;
            r_pend       <= '0;
            r_cur        <= '0;
            r_rf_ra      <= '0;
            r_cap_vld    <= 1'b0;
            r_cap_slot   <= '0;
            r_cap_addr   <= '0;
            r_cap_zero   <= 1'b0;
            r_opnd_valid <= 1'b0;
            r_opnd_tid   <= '0;
            for (int k = 0; k < NOPS; k++) begin
                r_regno[k] <= '0;
                r_opnd[k]  <= '0;
            end
        end else begin
            if (w_accept) begin
                r_tid  <= i_req_tid;
                r_mask <= i_req_mask;
                for (int k = 0; k < NOPS; k++) begin
                    r_regno[k] <= w_req_regno[k];
                    r_opnd[k]  <= '0;
                end
                if (i_req_mask != '0) begin
                    r_cur   <= w_req_first;
                    r_pend  <= i_req_mask & ~onehot(w_req_first);
                    r_rf_ra <= {i_req_tid, w_req_regno[w_req_first]};
                end
            end else begin
                if (r_state == S_ISSUE && r_pend != '0) begin
                    r_cur   <= w_pend_first;
                    r_pend  <= r_pend & ~onehot(w_pend_first);
                    r_rf_ra <= w_addr[w_pend_first];
                end
                for (int k = 0; k < NOPS; k++) begin
                    if (r_cap_vld && r_cap_slot == SW'(k)) begin
                        r_opnd[k] <= w_cap_val;
                    end else if (w_hold && r_mask[k] && !w_zero[k] &&
                                 w_addr[k] == i_wb_wa) begin
                        r_opnd[k] <= merge(r_opnd[k], i_wb_i, i_wb_wr);
                    end
                end
            end
            // Address sampled by the RF this edge returns data next cycle.
            r_cap_vld  <= (r_state == S_ISSUE);
            r_cap_slot <= r_cur;
            r_cap_addr <= r_rf_ra;
            r_cap_zero <= w_zero[r_cur];
            r_opnd_valid <= w_done || (r_opnd_valid && !i_opnd_ready);
            if (w_done) r_opnd_tid <= r_tid;
        end
    end

    assign o_rf_ra      = r_rf_ra;
    assign o_opnd_valid = r_opnd_valid;
    assign o_opnd_tid   = r_opnd_tid;
    assign o_opnd_a     = r_opnd[0];
    assign o_opnd_b     = r_opnd[1];
    assign o_opnd_c     = r_opnd[2];

endmodule

// File: tb/tb_gpr_operand_fetch.sv
// Scoreboard bench for gpr_operand_fetch: two instances (plain and
// zero-bypass) share stimulus and a behavioural register file.
module tb_gpr_operand_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, opnd_ready;
    logic [1:0]  req_tid;
    logic [5:0]  req_ra, req_rb, req_rc;
    logic [2:0]  req_mask;
    logic [3:0]  wb_wr;
    logic [7:0]  wb_wa;
    logic [31:0] wb_i;

    logic        req_ready0, req_ready1, ov0, ov1;
    logic [7:0]  rf_ra0, rf_ra1;
    logic [31:0] rf_o0, rf_o1;
    logic [1:0]  tid0, tid1;
    logic [31:0] a0, b0, c0, a1, b1, c1;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  tid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;
    logic [7:0] ra_seen[$];

    gpr_operand_fetch #(.ZERO_BYPASS(1'b0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready0),
        .i_req_tid(req_tid), .i_req_ra(req_ra), .i_req_rb(req_rb),
        .i_req_rc(req_rc), .i_req_mask(req_mask),
        .o_rf_ra(rf_ra0), .i_rf_o(rf_o0),
        .i_wb_wr(wb_wr), .i_wb_wa(wb_wa), .i_wb_i(wb_i),
        .o_opnd_valid(ov0), .i_opnd_ready(opnd_ready),
        .o_opnd_tid(tid0), .o_opnd_a(a0), .o_opnd_b(b0), .o_opnd_c(c0)
    );

    gpr_operand_fetch #(.ZERO_BYPASS(1'b1)) dut_z (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready1),
        .i_req_tid(req_tid), .i_req_ra(req_ra), .i_req_rb(req_rb),
        .i_req_rc(req_rc), .i_req_mask(req_mask),
        .o_rf_ra(rf_ra1), .i_rf_o(rf_o1),
        .i_wb_wr(wb_wr), .i_wb_wa(wb_wa), .i_wb_i(wb_i),
        .o_opnd_valid(ov1), .i_opnd_ready(opnd_ready),
        .o_opnd_tid(tid1), .o_opnd_a(a1), .o_opnd_b(b1), .o_opnd_c(c1)
    );

    // Register file: synchronous read (old data on collision), byte writes.
    always @(posedge clk) begin
        rf_o0 <= mem[rf_ra0];
        rf_o1 <= mem[rf_ra1];
        for (int j = 0; j < 4; j++) begin
            if (wb_wr[j]) mem[wb_wa][8*j +: 8] <= wb_i[8*j +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ov0 && opnd_ready) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon0 unexpected set: got a=%h want none", a0);
            end else begin
                m0 = q0.pop_front();
                chk("mon0 tid", {30'b0, tid0}, {30'b0, m0.tid});
                chk("mon0 a", a0, m0.a);
                chk("mon0 b", b0, m0.b);
                chk("mon0 c", c0, m0.c);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov1 && opnd_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon1 unexpected set: got a=%h want none", a1);
            end else begin
                m1 = q1.pop_front();
                chk("mon1 tid", {30'b0, tid1}, {30'b0, m1.tid});
                chk("mon1 a", a1, m1.a);
                chk("mon1 b", b1, m1.b);
                chk("mon1 c", c1, m1.c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wbw(input logic [7:0] addr, input logic [31:0] d);
        wb_wr = 4'hF;
        wb_wa = addr;
        wb_i  = d;
        tick();
        wb_wr = 4'h0;
    endtask

    task automatic send(
        input string nm, input logic [1:0] tid,
        input logic [5:0] ra, input logic [5:0] rb, input logic [5:0] rc,
        input logic [2:0] m, input int lat,
        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
        input logic [31:0] za, input int wb_at,
        input logic [3:0] wwr, input logic [7:0] wwa, input logic [31:0] wwi
    );
        exp_t e;
        int n;
        int k;
        req_tid   = tid;
        req_ra    = ra;
        req_rb    = rb;
        req_rc    = rc;
        req_mask  = m;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready0 && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " accept"}, {31'b0, req_ready0}, 32'd1);
        tick();
        req_valid = 1'b0;
        e.tid = tid;
        e.a = ea;
        e.b = eb;
        e.c = ec;
        q0.push_back(e);
        e.a = za;
        q1.push_back(e);
        ra_seen.delete();
        ra_seen.push_back(rf_ra0);
        k = 0;
        while (!ov0 && k < 12) begin
            if (k == wb_at - 1) begin
                wb_wr = wwr;
                wb_wa = wwa;
                wb_i  = wwi;
            end
            tick();
            k++;
            if (k == wb_at) wb_wr = 4'h0;
            ra_seen.push_back(rf_ra0);
        end
        chk({nm, " latency"}, k, lat);
        chk({nm, " zb valid"}, {31'b0, ov1}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        opnd_ready = 1'b1;
        req_tid = '0;
        req_ra = '0;
        req_rb = '0;
        req_rc = '0;
        req_mask = '0;
        wb_wr = '0;
        wb_wa = '0;
        wb_i = '0;
        tick();
        tick();
        #1;
        chk("reset req_ready", {31'b0, req_ready0}, 32'd0);
        wbw(8'h45, 32'h11111111);
        wbw(8'h46, 32'h22222222);
        wbw(8'h47, 32'h33333333);
        wbw(8'h49, 32'h00000005);
        wbw(8'h00, 32'hDEADBEEF);
        rst = 1'b0;
        tick();
        chk("reset valid", {31'b0, ov0}, 32'd0);
        chk("reset rf_ra", {24'b0, rf_ra0}, 32'd0);
        chk("reset opnd_a", a0, 32'd0);
        chk("reset tid", {30'b0, tid0}, 32'd0);
        chk("idle req_ready", {31'b0, req_ready0}, 32'd1);

        send("t1", 2'd1, 6'd5, 6'd6, 6'd7, 3'b111, 4,
             32'h11111111, 32'h22222222, 32'h33333333, 32'h11111111,
             0, 4'h0, 8'h00, 32'h0);
        chk("t1 ra0", {24'b0, ra_seen[0]}, 32'h45);
        chk("t1 ra1", {24'b0, ra_seen[1]}, 32'h46);
        chk("t1 ra2", {24'b0, ra_seen[2]}, 32'h47);

        send("t2", 2'd1, 6'd5, 6'd6, 6'd7, 3'b111, 4,
             32'h11111111, 32'h22BB22DD, 32'h33333333, 32'h11111111,
             3, 4'b0101, 8'h46, 32'hAABBCCDD);

        send("t3", 2'd1, 6'd5, 6'd6, 6'd7, 3'b010, 2,
             32'h0, 32'h22BB22DD, 32'h0, 32'h0, 0, 4'h0, 8'h00, 32'h0);

        send("t4", 2'd1, 6'd5, 6'd9, 6'd7, 3'b010, 2,
             32'h0, 32'h5, 32'h0, 32'h0, 0, 4'h0, 8'h00, 32'h0);
        chk("t4 ra0", {24'b0, ra_seen[0]}, 32'h49);

        send("t5", 2'd2, 6'd0, 6'd0, 6'd0, 3'b000, 1,
             32'h0, 32'h0, 32'h0, 32'h0, 0, 4'h0, 8'h00, 32'h0);
        chk("t5 rf_ra hold", {24'b0, rf_ra0}, 32'h49);

        send("t6", 2'd1, 6'd7, 6'd7, 6'd9, 3'b111, 4,
             32'h33333333, 32'h33333333, 32'h5, 32'h33333333,
             0, 4'h0, 8'h00, 32'h0);
        tick();

        opnd_ready = 1'b0;
        send("t7", 2'd1, 6'd5, 6'd5, 6'd0, 3'b011, 3,
             32'hFF111111, 32'hFF111111, 32'h0, 32'hFF111111,
             0, 4'h0, 8'h00, 32'h0);
        chk("t7 ready held0", {31'b0, req_ready0}, 32'd0);
        wb_wr = 4'b1000;
        wb_wa = 8'h45;
        wb_i  = 32'hFF000000;
        tick();
        wb_wr = 4'h0;
        chk("t7 ready held1", {31'b0, req_ready0}, 32'd0);
        chk("t7 tid held", {30'b0, tid0}, 32'd1);
        tick();
        chk("t7 ready held2", {31'b0, req_ready0}, 32'd0);
        tick();
        opnd_ready = 1'b1;
        #1;
        chk("t7 ready release", {31'b0, req_ready0}, 32'd1);

        send("t8", 2'd0, 6'd0, 6'd0, 6'd0, 3'b001, 2,
             32'hDEAD1234, 32'h0, 32'h0, 32'h0,
             2, 4'b0011, 8'h00, 32'h00001234);

        req_tid   = 2'd1;
        req_ra    = 6'd5;
        req_rb    = 6'd6;
        req_rc    = 6'd7;
        req_mask  = 3'b111;
        req_valid = 1'b1;
        #1;
        chk("t9 ready", {31'b0, req_ready0}, 32'd1);
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t9 ready in rst", {31'b0, req_ready0}, 32'd0);
        tick();
        rst = 1'b0;
        chk("t9 valid", {31'b0, ov0}, 32'd0);
        chk("t9 rf_ra", {24'b0, rf_ra0}, 32'd0);
        #1;
        chk("t9 req_ready", {31'b0, req_ready0}, 32'd1);
        repeat (4) tick();
        chk("t9 no result", {31'b0, ov0}, 32'd0);

        send("t10", 2'd1, 6'd5, 6'd6, 6'd7, 3'b111, 4,
             32'hFF111111, 32'h22BB22DD, 32'h33333333, 32'hFF111111,
             0, 4'h0, 8'h00, 32'h0);
        tick();

        for (int n = 0; n < 20 && (q0.size() != 0 || q1.size() != 0); n++) begin
            tick();
        end
        chk("drain q0", q0.size(), 32'd0);
        chk("drain q1", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
